// File: rtl/sram_boot_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_boot_bridge: boot-copies an init ROM into on-chip RAM, then bridges |
// | the CPU's active-low OE/WE memory port onto the 1-cycle-latency RAM.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_boot_bridge #(
  parameter int ADDR_W     = 10,
  parameter int INIT_WORDS = 256
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic              OE,
  input  logic              WE,
  input  logic [15:0]       Data_to_SRAM,
  output logic [15:0]       Data_from_SRAM,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata,
  output logic              cpu_hold,
  output logic              init_done
);

  typedef enum logic [1:0] {
    S_COPY  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // One extra bit so INIT_WORDS == 2^ADDR_W still has a reachable terminal value.
  localparam logic [ADDR_W:0] C_LAST_CNT = (ADDR_W+1)'(INIT_WORDS - 1);
  localparam logic [ADDR_W:0] C_CNT_ONE  = (ADDR_W+1)'(1);

  state_t              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic                wr_pend_q;
  logic                cpu_hold_q;
  logic                init_done_q;
  logic                rd_valid_q;
  logic                byp_valid_q;
  logic [15:0]         byp_data_q;
  logic                w_in_range;

  assign w_in_range = (ADDR[15:ADDR_W] == '0);
  assign cpu_hold   = cpu_hold_q;
  assign init_done  = init_done_q;

  always_comb begin
    rom_addr  = cnt_q[ADDR_W-1:0];
    ram_addr  = waddr_q;
    ram_wdata = rom_data;
    ram_we    = 1'b0;
    case (state_q)
      S_COPY, S_FLUSH: ram_we = wr_pend_q & ~Reset;
      S_RUN: begin
        ram_addr  = ADDR[ADDR_W-1:0];
        ram_wdata = Data_to_SRAM;
        ram_we    = ~WE & w_in_range & ~Reset;
      end
      default: ram_we = 1'b0;
    endcase
    // A same-cycle read+write returns the written word, not the RAM's stale read.
    if (byp_valid_q)     Data_from_SRAM = byp_data_q;
    else if (rd_valid_q) Data_from_SRAM = ram_rdata;
    else                 Data_from_SRAM = 16'h0000;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_COPY;
      cnt_q       <= '0;
      waddr_q     <= '0;
      wr_pend_q   <= 1'b0;
      cpu_hold_q  <= 1'b1;
      init_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      byp_valid_q <= 1'b0;
      byp_data_q  <= 16'h0000;
    end else begin
      case (state_q)
        S_COPY: begin
          waddr_q   <= cnt_q[ADDR_W-1:0];
          wr_pend_q <= 1'b1;
          cnt_q     <= cnt_q + C_CNT_ONE;
          if (cnt_q == C_LAST_CNT) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          wr_pend_q   <= 1'b0;
          cpu_hold_q  <= 1'b0;
          init_done_q <= 1'b1;
          state_q     <= S_RUN;
        end
        S_RUN: begin
          rd_valid_q  <= ~OE & WE & w_in_range;
          byp_valid_q <= ~OE & ~WE & w_in_range;
          byp_data_q  <= Data_to_SRAM;
        end
        default: state_q <= S_COPY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    assert (INIT_WORDS >= 1 && INIT_WORDS <= (1 << ADDR_W))
      else $error("sram_boot_bridge: INIT_WORDS out of range");
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_boot_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_boot_bridge: directed vector bench for sram_boot_bridge.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sram_boot_bridge;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic        OE;
  logic        WE;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic [9:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic        cpu_hold;
  logic        init_done;

  // Second instance: full-depth image (INIT_WORDS == 2^ADDR_W), CPU idle.
  logic [15:0] ADDR2 = 16'h0000;
  logic        OE2 = 1'b1;
  logic        WE2 = 1'b1;
  logic [15:0] Data_to_SRAM2 = 16'h0000;
  logic [15:0] Data_from_SRAM2;
  logic [3:0]  rom_addr2;
  logic [15:0] rom_data2;
  logic [3:0]  ram_addr2;
  logic [15:0] ram_wdata2;
  logic        ram_we2;
  logic [15:0] ram_rdata2;
  logic        cpu_hold2;
  logic        init_done2;

  logic [15:0] mem  [0:1023] = '{default: 16'h5555};
  logic [15:0] mem2 [0:15]   = '{default: 16'h0000};

  always #5 Clk = ~Clk;

  sram_boot_bridge #(.ADDR_W(10), .INIT_WORDS(256)) dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE),
    .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .cpu_hold(cpu_hold), .init_done(init_done)
  );

  sram_boot_bridge #(.ADDR_W(4), .INIT_WORDS(16)) dut2 (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR2), .OE(OE2), .WE(WE2),
    .Data_to_SRAM(Data_to_SRAM2), .Data_from_SRAM(Data_from_SRAM2),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_we(ram_we2),
    .ram_rdata(ram_rdata2), .cpu_hold(cpu_hold2), .init_done(init_done2)
  );

  // Synchronous ROMs and RAMs; RAM read-during-write returns the old word.
  always @(posedge Clk) begin
    rom_data  <= 16'hA000 + 16'(rom_addr);
    rom_data2 <= 16'hB000 + 16'(rom_addr2);
    if (ram_we)  mem[ram_addr]   <= ram_wdata;
    if (ram_we2) mem2[ram_addr2] <= ram_wdata2;
    ram_rdata  <= mem[ram_addr];
    ram_rdata2 <= mem2[ram_addr2];
  end

  typedef struct {
    logic        oe;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_we;
    logic [15:0] exp_dout;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Counts hold cycles of both instances from the first cycle with Reset low.
  task automatic count_hold(output int n1, output int n2, output int nz);
    n1 = 0; n2 = 0; nz = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!cpu_hold && !cpu_hold2) break;
      if (cpu_hold)  n1++;
      if (cpu_hold2) n2++;
      if (Data_from_SRAM !== 16'h0000) nz++;
      tick();
    end
  endtask

  function automatic int image_errors();
    int e = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== 16'hA000 + 16'(i)) e++;
    return e;
  endfunction

  vec_t vecs [13];
  int   h1, h2, nz, e2;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'hA010};
    vecs[1]  = '{1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0005, 16'h1234, 1'b1, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 16'h1234};
    vecs[4]  = '{1'b1, 1'b0, 16'hFFFF, 16'h7777, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 16'h0020, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[7]  = '{1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'hBEEF};
    vecs[8]  = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 1'b0, 16'hA0FF};
    vecs[9]  = '{1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'h5555};
    vecs[10] = '{1'b0, 1'b1, 16'h0400, 16'h0000, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 16'h03FF, 16'h0F0F, 1'b1, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 16'h03FF, 16'h0000, 1'b0, 16'h0F0F};

    // Reset state, CPU hammering a write to 0x0000 throughout the copy.
    Reset = 1'b1; OE = 1'b0; WE = 1'b0; ADDR = 16'h0000; Data_to_SRAM = 16'hDEAD;
    tick();
    chk("rst_cpu_hold",  cpu_hold, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_dout",      Data_from_SRAM, 0);
    chk("rst_ram_we",    ram_we, 0);
    Reset = 1'b0;
    count_hold(h1, h2, nz);
    chk("hold_cycles",      h1, 257);
    chk("hold_cycles_full", h2, 17);
    chk("dout_during_hold", nz, 0);
    chk("init_done",        init_done, 1);
    chk("init_done_full",   init_done2, 1);
    chk("ram0_not_cpu",     mem[0], 16'hA000);
    chk("image_errors",     image_errors(), 0);
    chk("ram256_untouched", mem[256], 16'h5555);
    e2 = 0;
    for (int i = 0; i < 16; i++) if (mem2[i] !== 16'hB000 + 16'(i)) e2++;
    chk("full_image_errors", e2, 0);

    // RUN-mode vectors: ram_we checked in-cycle, read data one cycle later.
    WE = 1'b1; OE = 1'b1;
    for (int v = 0; v < 13; v++) begin
      OE = vecs[v].oe; WE = vecs[v].we; ADDR = vecs[v].addr; Data_to_SRAM = vecs[v].wdata;
      #1;
      chk($sformatf("vec%0d_ram_we", v), ram_we, vecs[v].exp_we);
      tick();
      chk($sformatf("vec%0d_dout", v), Data_from_SRAM, vecs[v].exp_dout);
    end
    OE = 1'b1; WE = 1'b1;
    chk("ram20_beef", mem[32], 16'hBEEF);

    // Write issued in the Reset cycle must be dropped.
    Reset = 1'b1; WE = 1'b0; ADDR = 16'h0300; Data_to_SRAM = 16'hCAFE;
    #1;
    chk("rst_cycle_ram_we", ram_we, 0);
    tick();
    Reset = 1'b0; WE = 1'b1; OE = 1'b1;
    repeat (100) tick();
    chk("hold_at_100", cpu_hold, 1);
    Reset = 1'b1;
    tick();
    chk("restart_rom_addr", rom_addr, 0);
    Reset = 1'b0;
    count_hold(h1, h2, nz);
    chk("rehold_cycles", h1, 257);
    chk("reimage_errors", image_errors(), 0);
    chk("ram300_dropped", mem[768], 16'h5555);

    OE = 1'b0; ADDR = 16'h0005;
    tick();
    chk("reread_5", Data_from_SRAM, 16'hA005);
    OE = 1'b1;
    tick();
    chk("idle_dout", Data_from_SRAM, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_boot_bridge.md
Name: sram_boot_bridge

Overview:
- Sits directly downstream of the SLC-3 top level, on its memory side.
- Consumes ADDR, OE, WE and Data_to_SRAM, drives a synchronous on-chip RAM, and returns Data_from_SRAM.
- After every reset it first copies a program image from an init ROM into the RAM, holding the CPU with cpu_hold until the copy completes.
- It then bridges the CPU's active-low OE/WE memory protocol onto the RAM's 1-cycle-latency port.

Parameters:
- ADDR_W, 10: RAM/ROM word-address width; RAM depth is 2^ADDR_W x 16.
- INIT_WORDS, 256: number of words copied from ROM address 0 upward. Legal range is 1..2^ADDR_W; a simulation assertion fires if it is out of range.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ADDR  in  16  CPU word address (MAR).
- OE  in  1  CPU read enable, active-low.
- WE  in  1  CPU write enable, active-low.
- Data_to_SRAM  in  16  CPU write data.
- Data_from_SRAM  out  16  read data returned to the CPU.
- rom_addr  out  ADDR_W  init ROM address.
- rom_data  in  16  init ROM data, valid 1 cycle after rom_addr.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_we  out  1  RAM write strobe, active-high; the write commits at the same rising edge.
- ram_rdata  in  16  RAM read data, valid 1 cycle after ram_addr.
- cpu_hold  out  1  high while the copy runs; the top level ORs it into the CPU reset.
- init_done  out  1  high once the bridge is in RUN.

Behaviour:
- Clock and reset: one clock (Clk); Reset is synchronous and active-high. Reset has priority over all other inputs in every state.
- Reset values: state=COPY, cnt=0, wr_pend=0, cpu_hold=1, init_done=0, ram_we=0, Data_from_SRAM=16'h0000, rd_valid=0.
- FSM states: COPY, FLUSH, RUN.
- COPY:
  - rom_addr=cnt.
  - Last cycle's fetch is written this cycle: ram_we=wr_pend, ram_addr=cnt_d, ram_wdata=rom_data.
  - cnt_d and wr_pend are registered copies of cnt and "fetch issued".
  - cnt increments each cycle.
  - When cnt==INIT_WORDS-1, go to FLUSH next cycle.
- FLUSH: write the final word (ram_addr=INIT_WORDS-1), issue no new fetch, go to RUN.
- Copy timing: from the first cycle with Reset low, cpu_hold is high for exactly INIT_WORDS+1 cycles. On the following cycle cpu_hold=0 and init_done=1.
- RUN address path: ram_addr=ADDR[ADDR_W-1:0], combinational. in_range = (ADDR[15:ADDR_W]==0).
- RUN write: ram_we = ~WE & in_range; ram_wdata=Data_to_SRAM. A write repeats every cycle WE stays low; this is harmless.
- RUN read: ~OE & WE & in_range registers rd_valid=1 for the next cycle.
  - Data_from_SRAM = rd_valid ? ram_rdata : 16'h0000, so read latency is 1 cycle.
  - Out-of-range reads return 0 (addresses 0xFE00 upward belong to memory-mapped I/O, which Mem2IO handles).
  - With OE high, Data_from_SRAM is 0 on the following cycle.
- OE and WE both low in the same cycle:
  - The write wins and commits.
  - Next cycle Data_from_SRAM = the written data, via a registered bypass (byp_valid, byp_data).
  - The RAM's read-during-write result is ignored.
- Write then read of the same address on the next cycle returns the new data; the RAM commit at the edge guarantees this, so no bypass is needed.
- CPU inputs during COPY/FLUSH: ADDR, OE, WE and Data_to_SRAM are ignored. No CPU writes reach the RAM and Data_from_SRAM holds 0.
- Reset mid-copy or in RUN: returns to COPY with cnt=0 and restarts the full copy. A write in flight on the reset cycle is dropped, because ram_we is 0 during the Reset cycle.
- Boundary INIT_WORDS=1: COPY lasts 1 cycle, then FLUSH, then RUN; hold lasts 2 cycles.
- Boundary INIT_WORDS=2^ADDR_W: cnt is ADDR_W+1 bits wide, so the terminal compare does not wrap.

Test Plan:
1. ROM word i = 16'hA000+i, INIT_WORDS=256, Reset pulse 1 cycle -> cpu_hold high for exactly 257 cycles, then init_done=1. A backdoor check shows RAM[0..255]=A000..A0FF and RAM[256]=untouched.
2. RUN: ADDR=0x0010, OE=0, WE=1 -> Data_from_SRAM=16'hA010 exactly 1 cycle later and 0 the cycle after OE returns high.
3. RUN: ADDR=0x0005, WE=0, Data_to_SRAM=16'h1234 for 1 cycle, then an OE=0 read of 0x0005 -> returns 16'h1234. A write to 0xFFFF produces no ram_we, and a read of 0xFFFF returns 16'h0000.
4. OE=0 and WE=0 together at ADDR=0x0020, data 16'hBEEF -> RAM[0x20]=BEEF and Data_from_SRAM=16'hBEEF on the next cycle.
5. Assert Reset at copy cycle 100 -> cnt restarts at 0, cpu_hold stays high for another full 257 cycles, and final RAM contents match scenario 1.
6. CPU drives WE=0 to ADDR=0x0000 with 16'hDEAD throughout the copy -> after init RAM[0]=16'hA000, confirming CPU writes are ignored during hold.
